// File: rtl/digipot_sched.sv
// digipot_sched: owns the three digipot wiper shadows and serialises their
// programming through the shared Digipot_ctrl (mux/dato/ctrl), one transfer
// at a time, with round-robin arbitration among pending channels.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no transfer; grant the next pending channel if any
// SETUP | mux/dato settle for one clock, ctrl held high
// START | ctrl low for PULSE_CYCLES clocks (start strobe)
// WAIT  | ctrl high for XFER_CYCLES clocks while the serializer shifts
module digipot_sched #(
    parameter int          XFER_CYCLES  = 80,
    parameter int          PULSE_CYCLES = 1,
    parameter logic [7:0]  SHADOW_INIT  = 8'h80,
    parameter bit          INIT_LOAD    = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [1:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       refresh,
    input  logic [1:0] rd_addr,
    output logic [7:0] rd_data,
    output logic [1:0] mux,
    output logic       ctrl,
    output logic [7:0] dato,
    output logic       busy,
    output logic [2:0] pending
);

    localparam int CNT_MAX = (XFER_CYCLES > PULSE_CYCLES) ? XFER_CYCLES : PULSE_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        START = 2'd2,
        WAIT  = 2'd3
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [7:0]    shadow [3];
    logic [1:0]    rr_ptr;
    logic          grant_vld;
    logic [1:0]    grant_ch;
    logic          grant_take;
    logic          wr_hit;
    logic [2:0]    set_mask;
    logic [2:0]    clr_mask;
    logic [1:0]    cand0, cand1, cand2;

    function automatic logic [1:0] next_ch(input logic [1:0] c);
        return (c == 2'd2) ? 2'd0 : c + 2'd1;
    endfunction

    assign wr_hit   = wr_en && (wr_addr != 2'd3);
    assign set_mask = {3{refresh}} | (wr_hit ? (3'b001 << wr_addr) : 3'b000);
    assign clr_mask = grant_take ? (3'b001 << grant_ch) : 3'b000;

    assign ctrl    = (state != START);
    assign busy    = (state != IDLE);
    assign rd_data = (rd_addr == 2'd3) ? 8'h00 : shadow[rd_addr];

    // Round-robin search for the first pending channel after rr_ptr.
    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = 2'd0;
        cand0     = next_ch(rr_ptr);
        cand1     = next_ch(cand0);
        cand2     = next_ch(cand1);
        if (pending[cand0]) begin
            grant_vld = 1'b1;
            grant_ch  = cand0;
        end else if (pending[cand1]) begin
            grant_vld = 1'b1;
            grant_ch  = cand1;
        end else if (pending[cand2]) begin
            grant_vld = 1'b1;
            grant_ch  = cand2;
        end
    end

    // Next-state and phase counter; counter reloads on every state entry.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        grant_take = 1'b0;
        case (state)
            IDLE: begin
                if (grant_vld) begin
                    grant_take = 1'b1;
                    state_nx   = SETUP;
                    cnt_nx     = '0;
                end
            end
            SETUP: begin
                state_nx = START;
                cnt_nx   = CW'(PULSE_CYCLES - 1);
            end
            START: begin
                if (cnt == '0) begin
                    state_nx = WAIT;
                    cnt_nx   = CW'(XFER_CYCLES - 1);
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // State register and phase counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Grant side effects: latch channel/value and advance the round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mux    <= 2'd0;
            dato   <= 8'h00;
            rr_ptr <= 2'd2;
        end else if (grant_take) begin
            mux    <= grant_ch;
            dato   <= shadow[grant_ch];
            rr_ptr <= grant_ch;
        end
    end

    // Pending flags: a write or refresh set beats a same-edge grant clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= INIT_LOAD ? 3'b111 : 3'b000;
        end else begin
            pending <= (pending & ~clr_mask) | set_mask;
        end
    end

    // Shadow registers written by the EPP decoder.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                shadow[i] <= SHADOW_INIT;
            end
        end else if (wr_hit) begin
            shadow[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_digipot_sched.sv
// Directed bench for digipot_sched: expected transfers are queued as stimulus
// is applied and popped by a monitor at each ctrl falling edge.
`timescale 1ns/1ps
module tb_digipot_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [1:0] wr_addr = 2'd0;
    logic [7:0] wr_data = 8'h00;
    logic       refresh = 1'b0;
    logic [1:0] rd_addr = 2'd0;
    logic [7:0] rd_data;
    logic [1:0] mux;
    logic       ctrl;
    logic [7:0] dato;
    logic       busy;
    logic [2:0] pending;

    digipot_sched dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .refresh (refresh),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .mux     (mux),
        .ctrl    (ctrl),
        .dato    (dato),
        .busy    (busy),
        .pending (pending)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] mux;
        logic [7:0] dato;
    } xfer_t;

    int    n_assert = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    fall_count = 0;
    int    fall_cyc[$];
    int    low_w = 0;
    logic  ctrl_prev = 1'b1;
    xfer_t sb[$];
    int    e1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] m, input logic [7:0] d);
        xfer_t x;
        x.mux  = m;
        x.dato = d;
        sb.push_back(x);
    endtask

    task automatic write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
    endtask

    task automatic wait_falls(input int target, input string tag);
        int b;
        b = 0;
        while (fall_count < target && b < 2000) begin
            @(posedge clk);
            b++;
        end
        #1;
        check(tag, fall_count, target);
    endtask

    task automatic wait_idle(input string tag);
        int b;
        b = 0;
        while (busy && b < 500) begin
            @(posedge clk);
            #1;
            b++;
        end
        check(tag, busy, 1'b0);
    endtask

    // Monitor: score every transfer at its ctrl falling edge and check strobe width.
    always @(negedge clk) begin
        xfer_t e;
        if (rst_n) begin
            if (ctrl_prev && !ctrl) begin
                fall_count++;
                fall_cyc.push_back(cyc);
                check("sb_nonempty", sb.size() != 0, 1'b1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("xfer_mux", mux, e.mux);
                    check("xfer_dato", dato, e.dato);
                end
            end
            if (!ctrl) begin
                low_w++;
            end else if (!ctrl_prev) begin
                check("strobe_width", low_w, 1);
                low_w = 0;
            end
            ctrl_prev = ctrl;
        end
    end

    initial begin
        // Reset values and power-up programming of all three channels.
        #12;
        check("rst_ctrl", ctrl, 1'b1);
        check("rst_mux", mux, 2'd0);
        check("rst_dato", dato, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_pending", pending, 3'b111);
        check("rst_shadow", rd_data, 8'h80);
        push(2'd0, 8'h80);
        push(2'd1, 8'h80);
        push(2'd2, 8'h80);
        @(negedge clk);
        rst_n = 1'b1;
        wait_falls(3, "init_xfers");
        check("init_spacing1", fall_cyc[1] - fall_cyc[0], 83);
        check("init_spacing2", fall_cyc[2] - fall_cyc[1], 83);
        wait_idle("init_idle");
        check("init_pending", pending, 3'b000);

        // Single write from idle: latency and busy length.
        rd_addr = 2'd1;
        write(2'd1, 8'h55);
        push(2'd1, 8'h55);
        @(posedge clk); #1;
        check("wr_pending", pending, 3'b010);
        check("wr_readback", rd_data, 8'h55);
        check("wr_busy_e0", busy, 1'b0);
        @(negedge clk);
        wr_en = 1'b0;
        @(posedge clk); #1;
        e1 = cyc;
        check("grant_mux", mux, 2'd1);
        check("grant_dato", dato, 8'h55);
        check("grant_busy", busy, 1'b1);
        check("grant_ctrl", ctrl, 1'b1);
        @(posedge clk); #1;
        check("start_ctrl", ctrl, 1'b0);
        @(posedge clk); #1;
        check("after_start_ctrl", ctrl, 1'b1);
        wait_idle("wr_idle");
        check("busy_len", cyc - e1, 82);

        // Writes during a ch1 transfer: round-robin order and ch1 re-queue.
        write(2'd1, 8'h55);
        push(2'd1, 8'h55);
        @(negedge clk);
        wr_en = 1'b0;
        repeat (10) @(negedge clk);
        write(2'd0, 8'h22);
        write(2'd2, 8'h11);
        write(2'd1, 8'hAA);
        push(2'd2, 8'h11);
        push(2'd0, 8'h22);
        push(2'd1, 8'hAA);
        @(posedge clk); #1;
        wr_en = 1'b0;
        check("inflight_dato", dato, 8'h55);
        check("inflight_mux", mux, 2'd1);
        check("inflight_pending", pending, 3'b111);
        check("inflight_readback", rd_data, 8'hAA);
        wait_falls(8, "rr_xfers");
        wait_idle("rr_idle");

        // Address 3 is ignored; refresh re-sends current shadows.
        rd_addr = 2'd3;
        write(2'd3, 8'h99);
        @(negedge clk);
        wr_en = 1'b0;
        check("addr3_pending", pending, 3'b000);
        check("addr3_readback", rd_data, 8'h00);
        check("addr3_busy", busy, 1'b0);
        repeat (5) @(negedge clk);
        check("addr3_no_xfer", fall_count, 8);
        push(2'd2, 8'h11);
        push(2'd0, 8'h22);
        push(2'd1, 8'hAA);
        refresh = 1'b1;
        @(negedge clk);
        refresh = 1'b0;
        check("refresh_pending", pending, 3'b111);
        wait_falls(11, "refresh_xfers");
        wait_idle("refresh_idle");

        // Asynchronous reset during START aborts the transfer immediately.
        rd_addr = 2'd0;
        write(2'd0, 8'h77);
        push(2'd0, 8'h77);
        @(negedge clk);
        wr_en = 1'b0;
        for (int b = 0; b < 20 && ctrl; b++) @(negedge clk);
        check("abort_in_start", ctrl, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_ctrl", ctrl, 1'b1);
        check("abort_mux", mux, 2'd0);
        check("abort_dato", dato, 8'h00);
        check("abort_busy", busy, 1'b0);
        check("abort_pending", pending, 3'b111);
        check("abort_shadow", rd_data, 8'h80);
        push(2'd0, 8'h80);
        push(2'd1, 8'h80);
        push(2'd2, 8'h80);
        @(negedge clk);
        rst_n = 1'b1;
        wait_falls(15, "restart_xfers");
        wait_idle("restart_idle");
        check("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
